// File: rtl/sakebi_fcs_stream_if.sv
// AXI-Stream beat bundle (TVALID/TREADY/TDATA/TKEEP/TLAST) shared by the FCS engine's input and output ports.
interface sakebi_fcs_stream_if #(
   parameter int DATA_BYTES = 1
);
   logic                      TVALID;
   logic                      TREADY;
   logic [8*DATA_BYTES-1:0]   TDATA;
   logic [DATA_BYTES-1:0]     TKEEP;
   logic                      TLAST;

   modport master (
      output TVALID,
      output TDATA,
      output TKEEP,
      output TLAST,
      input  TREADY
   );

   modport slave (
      input  TVALID,
      input  TDATA,
      input  TKEEP,
      input  TLAST,
      output TREADY
   );
endinterface

// File: rtl/sakebi_fcs_stream.sv
// Inline Ethernet FCS (reflected CRC-32) engine: one-register AXI-Stream pass-through plus a held FCS/length result.
// Define SAKEBI_FCS_CHECK_EN to add the o_fcs_ok residue-check output for RX use.
module sakebi_fcs_stream #(
   parameter int          DATA_BYTES = 1,
   parameter logic [31:0] CRC_POLY   = 32'h04C11DB7,
   parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF,
   parameter int          LEN_WIDTH  = 16
) (
   input  logic                 i_axis_ACLK,
   input  logic                 i_axis_ARESETn,
   sakebi_fcs_stream_if.slave   s_axis,
   sakebi_fcs_stream_if.master  m_axis,
   output logic                 o_fcs_TVALID,
   input  logic                 i_fcs_TREADY,
   output logic [31:0]          o_fcs_TDATA,
   output logic [LEN_WIDTH-1:0] o_fcs_TUSER
`ifdef SAKEBI_FCS_CHECK_EN
   ,
   output logic                 o_fcs_ok
`endif
);

   localparam int TW = 8 * DATA_BYTES;
   localparam int KW = $clog2(DATA_BYTES + 1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BODY = 1'b1;

   function automatic logic [31:0] reflect32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = v[31-i];
      return r;
   endfunction

   localparam logic [31:0] POLY_REF = reflect32(CRC_POLY);

`ifdef SAKEBI_FCS_CHECK_EN
   localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
`endif

   // One byte folded LSB-first into the reflected register.
   function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
      logic [31:0] c;
      c = crc ^ {24'h0, b};
      for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ POLY_REF) : (c >> 1);
      return c;
   endfunction

   function automatic logic [LEN_WIDTH-1:0] sat_add(input logic [LEN_WIDTH-1:0] a, input logic [KW-1:0] n);
      logic [LEN_WIDTH:0] s;
      s = {1'b0, a} + {{(LEN_WIDTH + 1 - KW){1'b0}}, n};
      return s[LEN_WIDTH] ? {LEN_WIDTH{1'b1}} : s[LEN_WIDTH-1:0];
   endfunction

   logic [0:0]           state_p0;
   logic [31:0]          crc_p0;
   logic [LEN_WIDTH-1:0] cnt_p0;

   logic                 vld_p1;
   logic [TW-1:0]        tdata_p1;
   logic [DATA_BYTES-1:0] tkeep_p1;
   logic                 tlast_p1;

   logic                 fcs_vld_p1;
   logic [31:0]          fcs_data_p1;
   logic [LEN_WIDTH-1:0] fcs_len_p1;
`ifdef SAKEBI_FCS_CHECK_EN
   logic                 fcs_ok_p1;
`endif

   logic                 last_stall;
   logic                 s_ready;
   logic                 accept;
   logic [31:0]          crc_nxt;
   logic [KW-1:0]        kept;
   logic [LEN_WIDTH-1:0] cnt_nxt;

   // A last beat may only enter once the previous result slot is free (or being freed).
   assign last_stall    = s_axis.TLAST && fcs_vld_p1 && !i_fcs_TREADY;
   assign s_ready       = (!vld_p1 || m_axis.TREADY) && !last_stall;
   assign s_axis.TREADY = s_ready;
   assign accept        = s_axis.TVALID && s_ready;

   always_comb begin
      crc_nxt = (state_p0 == ST_IDLE) ? CRC_INIT : crc_p0;
      kept    = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         if (s_axis.TKEEP[i]) begin
            crc_nxt = crc_byte(crc_nxt, s_axis.TDATA[8*i +: 8]);
            kept    = kept + KW'(1);
         end
      end
      cnt_nxt = sat_add((state_p0 == ST_IDLE) ? '0 : cnt_p0, kept);
   end

   // ---- p0: frame accumulation state ----
   always_ff @(posedge i_axis_ACLK) begin
      if (!i_axis_ARESETn) begin
         state_p0 <= ST_IDLE;
         crc_p0   <= CRC_INIT;
         cnt_p0   <= '0;
      end else if (accept) begin
         if (s_axis.TLAST) begin
            state_p0 <= ST_IDLE;
            crc_p0   <= CRC_INIT;
            cnt_p0   <= '0;
         end else begin
            state_p0 <= ST_BODY;
            crc_p0   <= crc_nxt;
            cnt_p0   <= cnt_nxt;
         end
      end
   end

   // ---- p1: pass-through register stage ----
   always_ff @(posedge i_axis_ACLK) begin
      if (!i_axis_ARESETn) begin
         vld_p1 <= 1'b0;
      end else if (accept) begin
         vld_p1 <= 1'b1;
      end else if (m_axis.TREADY) begin
         vld_p1 <= 1'b0;
      end
   end

   always_ff @(posedge i_axis_ACLK) begin
      if (accept) begin
         tdata_p1 <= s_axis.TDATA;
         tkeep_p1 <= s_axis.TKEEP;
         tlast_p1 <= s_axis.TLAST;
      end
   end

   // ---- p1: held FCS result; a fresh load overrides a same-cycle accept ----
   always_ff @(posedge i_axis_ACLK) begin
      if (!i_axis_ARESETn) begin
         fcs_vld_p1  <= 1'b0;
         fcs_data_p1 <= '0;
         fcs_len_p1  <= '0;
`ifdef SAKEBI_FCS_CHECK_EN
         fcs_ok_p1   <= 1'b0;
`endif
      end else if (accept && s_axis.TLAST) begin
         fcs_vld_p1  <= 1'b1;
         fcs_data_p1 <= ~crc_nxt;
         fcs_len_p1  <= cnt_nxt;
`ifdef SAKEBI_FCS_CHECK_EN
         fcs_ok_p1   <= (crc_nxt == RESIDUE);
`endif
      end else if (i_fcs_TREADY) begin
         fcs_vld_p1  <= 1'b0;
      end
   end

   assign m_axis.TVALID = vld_p1;
   assign m_axis.TDATA  = tdata_p1;
   assign m_axis.TKEEP  = tkeep_p1;
   assign m_axis.TLAST  = tlast_p1;

   assign o_fcs_TVALID  = fcs_vld_p1;
   assign o_fcs_TDATA   = fcs_data_p1;
   assign o_fcs_TUSER   = fcs_len_p1;
`ifdef SAKEBI_FCS_CHECK_EN
   assign o_fcs_ok      = fcs_ok_p1;
`endif

endmodule
